div: RTL and testbench

- Sequential 32-bit signed integer divider for the multicycle CPU's DIV instruction.
- Operands come from the A/B operand muxes: dividend through mux6, divisor through mux7.
- Results go to the HI/LO input muxes: remainder to HI via mux11 data 1, quotient to LO via mux14 data 1.
- Handshakes with the control unit through a start/stop pair, matching the multiplier's. It adds a divide-by-zero flag that the control unit routes to its exception sequence.

---
 rtl/div_if.sv | 27 ++
 rtl/div.sv | 117 +++++++++++
 tb/tb_div.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Operand/result bundle between the control unit and the sequential divider.
// The control unit holds the master side; the divider holds the slave side.
interface div_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             start;
    logic             stop;
    logic             busy;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // start is a level request taken only while the divider sits in IDLE.
    // stop and div_zero are single-cycle pulses that never overlap;
    // hi/lo are valid in the stop cycle and hold until the next result.
    modport master (
        output dividend, divisor, start,
        input  stop, busy, div_zero, hi, lo
    );

    modport slave (
        input  dividend, divisor, start,
        output stop, busy, div_zero, hi, lo
    );
endinterface

// File: rtl/div.sv
// Sequential signed restoring divider: one quotient bit per clock on the
// magnitudes, sign fix-up in a final cycle; remainder to hi, quotient to lo.
module div #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    div_if.slave       bus,
    output logic [2:0] o_state
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_FIX  = 3'd2,
        S_DONE = 3'd3,
        S_ZERO = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_stop;
    logic             r_busy;
    logic             r_zero;

    logic [WIDTH-1:0] w_abs_dividend;
    logic [WIDTH-1:0] w_abs_divisor;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    // Two's-complement negation leaves the most negative value unchanged,
    // which reads correctly as the unsigned magnitude 2^(WIDTH-1).
    assign w_abs_dividend = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_abs_divisor  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    // rem < divisor always holds, so the shifted remainder fits in WIDTH+1 bits.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_stop   <= 1'b0;
            r_busy   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_stop <= 1'b0;
            r_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            r_state <= S_ZERO;
                            r_zero  <= 1'b1;
                        end else begin
                            r_state  <= S_RUN;
                            r_busy   <= 1'b1;
                            r_quo    <= w_abs_dividend;
                            r_dvs    <= w_abs_divisor;
                            r_rem    <= '0;
                            r_sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            r_sign_r <= bus.dividend[WIDTH-1];
                            r_cnt    <= CW'(WIDTH - 1);
                        end
                    end
                end
                S_RUN: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend.
                    r_lo    <= r_sign_q ? -r_quo : r_quo;
                    r_hi    <= r_sign_r ? -r_rem : r_rem;
                    r_busy  <= 1'b0;
                    r_stop  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: r_state <= S_IDLE;
                S_ZERO: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stop     = r_stop;
    assign bus.busy     = r_busy;
    assign bus.div_zero = r_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign o_state      = r_state;
endmodule

// File: tb/tb_div.sv
// Bench for the sequential divider: directed vector table, hand-written
// reset/restart sequences, and random operands against a plain-arithmetic model.
module tb_div;
  logic       clk;
  logic       reset;
  logic [2:0] dut_state;

  div_if #(.WIDTH(32)) bus ();

  div #(.WIDTH(32)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_state (dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          is_zero;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference: 64-bit signed arithmetic gives truncating quotient and a
  // dividend-signed remainder; low 32 bits give the wrapped overflow case.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo, output logic [31:0] hi);
    longint sa;
    longint sb;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    lo = q[31:0];
    hi = r[31:0];
  endtask

  // driver: one start pulse, then observe 40 cycles after the accepting edge
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n, output int zero_n,
                        output int zero_k, output int stop_n);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1; busy_n = 0; zero_n = 0; zero_k = -1; stop_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.busy) busy_n++;
      if (bus.div_zero) begin
        zero_n++;
        if (zero_k < 0) zero_k = k;
      end
      if (bus.stop) begin
        stop_n++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  // applies one operation and checks it against the scoreboard entry
  task automatic do_and_check(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat, busy_n, zero_n, zero_k, stop_n;
    logic [63:0] e;
    run_op(a, b, lat, busy_n, zero_n, zero_k, stop_n);
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, e[31:0]});
      check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, e[63:32]});
    end
    if (b == 32'd0) begin
      check({tag, " div_zero count"}, 64'(zero_n), 64'd1);
      check({tag, " div_zero cycle"}, 64'(zero_k), 64'd0);
      check({tag, " stop count"}, 64'(stop_n), 64'd0);
      check({tag, " busy cycles"}, 64'(busy_n), 64'd0);
    end else begin
      check({tag, " stop latency"}, 64'(lat), 64'd33);
      check({tag, " stop count"}, 64'(stop_n), 64'd1);
      check({tag, " busy cycles"}, 64'(busy_n), 64'd33);
      check({tag, " div_zero count"}, 64'(zero_n), 64'd0);
    end
    check({tag, " end state"}, {61'd0, dut_state}, 64'd0);
  endtask

  vec_t vecs[10];
  logic [31:0] m_lo, m_hi;

  initial begin
    int lat, stop_n;
    bit kick;
    logic [31:0] ra, rb;
    n_cmp = 0;
    n_bad = 0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.start    = 1'b0;
    reset        = 1'b1;

    vecs[0] = '{32'd100,       32'd7,          1'b0, 32'h0000000E, 32'h00000002};
    vecs[1] = '{32'hFFFFFF9C,  32'd7,          1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE};
    vecs[2] = '{32'd100,       32'hFFFFFFF9,   1'b0, 32'hFFFFFFF2, 32'h00000002};
    vecs[3] = '{32'd7,         32'd0,          1'b1, 32'hFFFFFFF2, 32'h00000002};
    vecs[4] = '{32'h80000000,  32'hFFFFFFFF,   1'b0, 32'h80000000, 32'h00000000};
    vecs[5] = '{32'h80000000,  32'd1,          1'b0, 32'h80000000, 32'h00000000};
    vecs[6] = '{32'd0,         32'd5,          1'b0, 32'h00000000, 32'h00000000};
    vecs[7] = '{32'hFFFFFFFF,  32'd2,          1'b0, 32'h00000000, 32'hFFFFFFFF};
    vecs[8] = '{32'h7FFFFFFF,  32'h80000000,   1'b0, 32'h00000000, 32'h7FFFFFFF};
    vecs[9] = '{32'h80000000,  32'h80000000,   1'b0, 32'h00000001, 32'h00000000};

    repeat (3) @(posedge clk);
    #1;
    check("reset stop", {63'd0, bus.stop}, 64'd0);
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset div_zero", {63'd0, bus.div_zero}, 64'd0);
    check("reset hi", {32'd0, bus.hi}, 64'd0);
    check("reset lo", {32'd0, bus.lo}, 64'd0);
    check("reset state", {61'd0, dut_state}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // directed table
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({vecs[i].hi, vecs[i].lo});
      do_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
    end

    // reset at iteration 10 of 1000/3
    @(negedge clk);
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset hi", {32'd0, bus.hi}, 64'd0);
    check("midreset lo", {32'd0, bus.lo}, 64'd0);
    check("midreset busy", {63'd0, bus.busy}, 64'd0);
    check("midreset stop", {63'd0, bus.stop}, 64'd0);
    check("midreset state", {61'd0, dut_state}, 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    stop_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.stop || bus.div_zero || bus.busy) stop_n++;
    end
    check("midreset quiet", 64'(stop_n), 64'd0);
    exp_q.push_back({32'd1, 32'd4});
    do_and_check("after reset 9/2", 32'd9, 32'd2);

    // 50/5 with a restart attempt mid-run and another while stop is high
    @(negedge clk);
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    stop_n = 0;
    lat    = -1;
    kick   = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 10) begin
        bus.dividend = 32'd9;
        bus.divisor  = 32'd2;
        bus.start    = 1'b1;
      end else if (k == 11) begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (kick) begin
        bus.start = 1'b0;
        kick = 1'b0;
        check("done restart busy", {63'd0, bus.busy}, 64'd0);
        check("done restart state", {61'd0, dut_state}, 64'd0);
      end
      if (bus.stop) begin
        stop_n++;
        if (lat < 0) lat = k;
        bus.start = 1'b1;
        kick = 1'b1;
      end
    end
    check("restart stop count", 64'(stop_n), 64'd1);
    check("restart latency", 64'(lat), 64'd33);
    check("restart lo", {32'd0, bus.lo}, 64'd10);
    check("restart hi", {32'd0, bus.hi}, 64'd0);
    m_lo = 32'd10;
    m_hi = 32'd0;

    // random operands against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        3: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      if (rb != 32'd0) model(ra, rb, m_lo, m_hi);
      exp_q.push_back({m_hi, m_lo});
      do_and_check($sformatf("rand%0d", i), ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
